// File: rtl/sun_pll_pkg.sv
// rtl/sun_pll_pkg.sv - shared types and default constants for the PLL lock detector
package sun_pll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } lockdet_state_t;

  localparam int SUN_PLL_DIV_N      = 32;
  localparam int SUN_PLL_TOL        = 1;
  localparam int SUN_PLL_LOCK_CNT   = 8;
  localparam int SUN_PLL_UNLOCK_CNT = 2;

endpackage

// File: rtl/sun_pll_sync2.sv
// rtl/sun_pll_sync2.sv - two-flop synchronizer with rising-edge pulse
module sun_pll_sync2 (
  input  logic CK,
  input  logic RST,
  input  logic D,
  output logic Q,
  output logic RISE
);

  logic meta;
  logic sync;
  logic prev;

  // Metastability chain plus one history flop for edge detection
  always_ff @(posedge CK) begin
    if (RST) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= D;
      sync <= meta;
      prev <= sync;
    end
  end

  assign Q    = sync;
  assign RISE = sync & ~prev;

endmodule

// File: rtl/sun_pll_lockdet.sv
// rtl/sun_pll_lockdet.sv - PLL lock detector and frequency monitor on CK
module sun_pll_lockdet
  import sun_pll_pkg::*;
#(
  parameter int DIV_N      = SUN_PLL_DIV_N,
  parameter int TOL        = SUN_PLL_TOL,
  parameter int LOCK_CNT   = SUN_PLL_LOCK_CNT,
  parameter int UNLOCK_CNT = SUN_PLL_UNLOCK_CNT,
  parameter int CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CK_REF,
  input  logic             PWRUP_1V8,
  output logic             LOCK,
  output logic             CNT_VALID,
  output logic [CNT_W-1:0] CNT_LAST,
  output logic             ERR_FAST,
  output logic             ERR_SLOW
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  PER_LO    = CNT_W'(DIV_N - TOL);
  localparam logic [CNT_W-1:0]  PER_HI    = CNT_W'(DIV_N + TOL);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

  lockdet_state_t   state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [GOOD_W-1:0] good_cnt, good_n;
  logic [BAD_W-1:0]  bad_cnt, bad_n;
  logic             lock_n, valid_n, fast_n, slow_n;
  logic [CNT_W-1:0] last_n;
  logic             ref_tick;
  logic             too_fast, too_slow, per_good, saturated;

  sun_pll_sync2 u_ref_sync (
    .CK   (CK),
    .RST  (RST),
    .D    (CK_REF),
    .Q    (),
    .RISE (ref_tick)
  );

  assign saturated = (cnt == CNT_MAX);
  assign cnt_inc   = saturated ? CNT_MAX : cnt + CNT_W'(1);
  assign too_fast  = (cnt < PER_LO);
  assign too_slow  = (cnt > PER_HI);
  assign per_good  = !too_fast && !too_slow;

  // State, counters and all outputs registered together so LOCK comes straight from a flop
  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      LOCK      <= 1'b0;
      CNT_VALID <= 1'b0;
      CNT_LAST  <= '0;
      ERR_FAST  <= 1'b0;
      ERR_SLOW  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      LOCK      <= lock_n;
      CNT_VALID <= valid_n;
      CNT_LAST  <= last_n;
      ERR_FAST  <= fast_n;
      ERR_SLOW  <= slow_n;
    end
  end

  // Next state: power-down beats timeout, timeout beats the per-tick measurement
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    lock_n  = LOCK;
    valid_n = 1'b0;
    last_n  = CNT_LAST;
    fast_n  = ERR_FAST;
    slow_n  = ERR_SLOW;

    if (!PWRUP_1V8) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
      bad_n   = '0;
      lock_n  = 1'b0;
      fast_n  = 1'b0;
      slow_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = FIRST;
        end
        FIRST: begin
          cnt_n = ref_tick ? CNT_W'(1) : cnt_inc;
          if (ref_tick) begin
            state_n = TRACK;
            good_n  = '0;
            bad_n   = '0;
          end
        end
        TRACK, LOCKED: begin
          cnt_n = ref_tick ? CNT_W'(1) : cnt_inc;
          if (ref_tick) begin
            valid_n = 1'b1;
            last_n  = cnt;
            if (too_fast) fast_n = 1'b1;
            if (too_slow) slow_n = 1'b1;
          end
          if (saturated) begin
            // Reference vanished: drop lock immediately, ignoring hysteresis
            slow_n  = 1'b1;
            lock_n  = 1'b0;
            state_n = FIRST;
            good_n  = '0;
            bad_n   = '0;
          end else if (ref_tick) begin
            if (state == TRACK) begin
              if (per_good) begin
                if (good_cnt == GOOD_LAST) begin
                  state_n = LOCKED;
                  lock_n  = 1'b1;
                  good_n  = '0;
                  bad_n   = '0;
                end else begin
                  good_n = good_cnt + GOOD_W'(1);
                end
              end else begin
                good_n = '0;
              end
            end else begin
              if (per_good) begin
                bad_n = '0;
              end else if (bad_cnt == BAD_LAST) begin
                state_n = TRACK;
                lock_n  = 1'b0;
                good_n  = '0;
                bad_n   = '0;
              end else begin
                bad_n = bad_cnt + BAD_W'(1);
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sun_pll_lockdet.sv
// tb/tb_sun_pll_lockdet.sv - self-checking bench for sun_pll_lockdet
module tb_sun_pll_lockdet;

  localparam int DIV_N      = 32;
  localparam int TOL        = 1;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 2;
  localparam int CNT_W      = 8;
  localparam int SAT        = 255;

  logic             CK = 1'b0;
  logic             RST;
  logic             CK_REF;
  logic             PWRUP_1V8;
  logic             LOCK;
  logic             CNT_VALID;
  logic [CNT_W-1:0] CNT_LAST;
  logic             ERR_FAST;
  logic             ERR_SLOW;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: history of the reference edges reduced to counters and flags
  bit m_armed, m_lock, m_fast, m_slow;
  int m_good, m_bad, m_last, m_prev_p;

  sun_pll_lockdet #(
    .DIV_N(DIV_N), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .CK_REF    (CK_REF),
    .PWRUP_1V8 (PWRUP_1V8),
    .LOCK      (LOCK),
    .CNT_VALID (CNT_VALID),
    .CNT_LAST  (CNT_LAST),
    .ERR_FAST  (ERR_FAST),
    .ERR_SLOW  (ERR_SLOW)
  );

  always #5 CK = ~CK;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_valid);
    chk({tag, "_valid"}, 32'(CNT_VALID), int'(exp_valid));
    chk({tag, "_last"},  32'(CNT_LAST),  m_last);
    chk({tag, "_lock"},  32'(LOCK),      int'(m_lock));
    chk({tag, "_fast"},  32'(ERR_FAST),  int'(m_fast));
    chk({tag, "_slow"},  32'(ERR_SLOW),  int'(m_slow));
  endtask

  task automatic model_clear(input bit clear_last);
    m_armed = 0; m_lock = 0; m_fast = 0; m_slow = 0;
    m_good = 0; m_bad = 0;
    if (clear_last) m_last = 0;
  endtask

  // One reference edge: the period ending here is the previous call's length
  task automatic model_tick(output bit v);
    int  per;
    bit  good;
    if (!m_armed) begin
      v = 0;
      m_armed = 1;
      m_good = 0;
      m_bad = 0;
    end else begin
      per = (m_prev_p > SAT) ? SAT : m_prev_p;
      v = 1;
      m_last = per;
      if (per < DIV_N - TOL) m_fast = 1;
      if (per > DIV_N + TOL) m_slow = 1;
      good = (per - DIV_N <= TOL) && (DIV_N - per <= TOL);
      if (!m_lock) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_lock = 1;
            m_bad = 0;
          end
        end else begin
          m_good = 0;
        end
      end else begin
        if (good) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == UNLOCK_CNT) begin
            m_lock = 0;
            m_good = 0;
            m_bad = 0;
          end
        end
      end
    end
  endtask

  // Drive one CK_REF period of p cycles; the rising edge is seen by the detector at step 3
  task automatic ref_cycle(input int p, input bit drop);
    bit exp_valid;
    CK_REF = 1'b1;
    for (int j = 1; j <= p; j++) begin
      step();
      if (j == 2) begin
        chk("pre_lock", 32'(LOCK), int'(m_lock));
        chk("pre_valid", 32'(CNT_VALID), 0);
      end
      if (j == 3) begin
        if (drop) begin
          exp_valid = 0;
          model_clear(0);
          chk_all("drop", exp_valid);
        end else begin
          model_tick(exp_valid);
          chk_all("tick", exp_valid);
        end
      end
      if (j == 4) chk("post_valid", 32'(CNT_VALID), 0);
      if (j == SAT + 2 && m_armed) begin
        chk("pre_to_lock", 32'(LOCK), int'(m_lock));
        chk("pre_to_slow", 32'(ERR_SLOW), int'(m_slow));
      end
      if (j == SAT + 3 && m_armed) begin
        m_armed = 0; m_lock = 0; m_slow = 1; m_good = 0; m_bad = 0;
        chk("to_lock", 32'(LOCK), 0);
        chk("to_slow", 32'(ERR_SLOW), 1);
        chk("to_valid", 32'(CNT_VALID), 0);
      end
      if (drop && j == 2) PWRUP_1V8 = 1'b0;
      if (j == p / 2) CK_REF = 1'b0;
    end
    m_prev_p = p;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    chk("rst_lock",  32'(LOCK), 0);
    chk("rst_valid", 32'(CNT_VALID), 0);
    chk("rst_last",  32'(CNT_LAST), 0);
    chk("rst_fast",  32'(ERR_FAST), 0);
    chk("rst_slow",  32'(ERR_SLOW), 0);
    RST = 1'b0;
    model_clear(1);
  endtask

  task automatic pwr_on();
    PWRUP_1V8 = 1'b1;
    step();
    step();
  endtask

  initial begin
    RST = 1'b1;
    CK_REF = 1'b0;
    PWRUP_1V8 = 1'b0;
    m_prev_p = 0;
    model_clear(1);
    do_reset();
    pwr_on();

    // Ideal reference: lock after eight good periods
    for (int i = 0; i < 12; i++) ref_cycle(32, 0);
    chk("ideal_locked", 32'(LOCK), 1);

    // One fast period keeps lock, two in a row drop it
    ref_cycle(29, 0);
    ref_cycle(32, 0);
    ref_cycle(32, 0);
    ref_cycle(29, 0);
    ref_cycle(29, 0);
    ref_cycle(32, 0);

    // Alternating 31/33 with a single 34 in the middle of tracking
    for (int i = 0; i < 4; i++) ref_cycle((i % 2) ? 31 : 33, 0);
    ref_cycle(34, 0);
    for (int i = 0; i < 12; i++) ref_cycle((i % 2) ? 31 : 33, 0);

    // Randomized periods around nominal
    for (int i = 0; i < 40; i++) ref_cycle(int'($urandom_range(28, 36)), 0);

    // Relock, then a stuck reference times out and relocks later
    for (int i = 0; i < 11; i++) ref_cycle(32, 0);
    ref_cycle(300, 0);
    for (int i = 0; i < 11; i++) ref_cycle(32, 0);
    chk("relock_after_to", 32'(LOCK), 1);

    // Power-down coinciding with a tick, then power back up
    ref_cycle(32, 1);
    pwr_on();
    for (int i = 0; i < 10; i++) ref_cycle(32, 0);

    // Reset in the middle of tracking, then the ideal sequence again
    for (int i = 0; i < 3; i++) ref_cycle(int'($urandom_range(31, 33)), 0);
    do_reset();
    for (int i = 0; i < 12; i++) ref_cycle(32, 0);
    chk("final_locked", 32'(LOCK), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
